minisrc_control_sequencer: RTL and testbench

Hardwired control sequencer for the Mini SRC datapath. It walks each instruction through fetch and execute steps. In every cycle it drives the one-hot source enables that select the shared 32-bit bus, the register load enables, the ALU operation and the memory strobes. The bus mux gives priority to the last asserted source, so this block guarantees that at most one `*out` enable is high in any cycle.

---
 rtl/minisrc_control_sequencer.sv | 236 +++++++++++++++++++++++
 tb/tb_minisrc_control_sequencer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/minisrc_control_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : minisrc_control_sequencer
// Purpose  : Hardwired fetch/execute control sequencer for the Mini SRC
//            datapath. Drives one-hot bus source enables, register load
//            enables, ALU function and memory strobes per T-step.
// Ports    : clock, reset (sync, active-high), run, ir[31:0], mem_ready
//            -> r_out/r_in[15:0], bus source enables (*_out), load/control
//            strobes (*_in, inc_pc, mdr_rd), read/write, alu_op[4:0],
//            step[2:0], halted, illegal (1-cycle pulse), mem_err (sticky).
// Revision : 1.0 - initial release
// ============================================================================
module minisrc_control_sequencer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        run,
  input  logic [31:0] ir,
  input  logic        mem_ready,
  output logic [15:0] r_out,
  output logic [15:0] r_in,
  output logic        pc_out,
  output logic        mdr_out,
  output logic        zhi_out,
  output logic        zlo_out,
  output logic        c_out,
  output logic        hi_out,
  output logic        lo_out,
  output logic        inport_out,
  output logic        pc_in,
  output logic        inc_pc,
  output logic        mar_in,
  output logic        mdr_in,
  output logic        mdr_rd,
  output logic        ir_in,
  output logic        y_in,
  output logic        z_in,
  output logic        hi_in,
  output logic        lo_in,
  output logic        read,
  output logic        write,
  output logic [4:0]  alu_op,
  output logic [2:0]  step,
  output logic        halted,
  output logic        illegal,
  output logic        mem_err
);

  localparam logic [3:0] S_IDLE = 4'd0, S_T0 = 4'd1, S_T1 = 4'd2, S_T2 = 4'd3,
                         S_T3 = 4'd4, S_T4 = 4'd5, S_T5 = 4'd6, S_T6 = 4'd7,
                         S_T7 = 4'd8, S_HALT = 4'd9;

  localparam logic [4:0] OP_LD  = 5'b00000, OP_LDI = 5'b00001, OP_ST  = 5'b00010,
                         OP_ADDI = 5'b01100, OP_ANDI = 5'b01101, OP_ORI = 5'b01110,
                         OP_MUL = 5'b01111, OP_DIV = 5'b10000,
                         OP_NOP = 5'b11010, OP_HALT = 5'b11011;

  localparam logic [4:0] ALU_ADD = 5'b00011, ALU_AND = 5'b00101,
                         ALU_OR  = 5'b00110, ALU_INC4 = 5'b11111;

  localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  logic [3:0]        state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              mem_err_q, mem_err_d;
  logic              illegal_q, illegal_d;

  // Instruction field decode
  logic [4:0]  w_op;
  logic [15:0] w_ra_oh, w_rb_oh, w_rc_oh;
  logic        w_alu3, w_imm, w_muldiv, w_ldi, w_ld, w_st, w_nop, w_halt, w_known;
  logic        w_mem_state, w_timeout;
  logic [3:0]  w_end_state;
  logic        w_unused_ir;

  assign w_op        = ir[31:27];
  assign w_ra_oh     = 16'd1 << ir[26:23];
  assign w_rb_oh     = 16'd1 << ir[22:19];
  assign w_rc_oh     = 16'd1 << ir[18:15];
  assign w_unused_ir = &{1'b0, ir[14:0]};

  assign w_alu3   = (w_op >= 5'b00011) && (w_op <= 5'b00110);
  assign w_imm    = (w_op == OP_ADDI) || (w_op == OP_ANDI) || (w_op == OP_ORI);
  assign w_muldiv = (w_op == OP_MUL) || (w_op == OP_DIV);
  assign w_ldi    = (w_op == OP_LDI);
  assign w_ld     = (w_op == OP_LD);
  assign w_st     = (w_op == OP_ST);
  assign w_nop    = (w_op == OP_NOP);
  assign w_halt   = (w_op == OP_HALT);
  assign w_known  = w_alu3 | w_imm | w_muldiv | w_ldi | w_ld | w_st | w_nop | w_halt;

  // States that stall on mem_ready and are therefore subject to the timeout
  assign w_mem_state = (state_q == S_T1) || ((state_q == S_T6) && w_ld) ||
                       ((state_q == S_T7) && w_st);
  assign w_timeout   = w_mem_state && !mem_ready && (wait_q == WAIT_LAST);
  assign w_end_state = run ? S_T0 : S_IDLE;

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      wait_q    <= '0;
      mem_err_q <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      mem_err_q <= mem_err_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    wait_d    = '0;
    mem_err_d = mem_err_q;
    illegal_d = 1'b0;
    if (w_mem_state && !mem_ready && !w_timeout) begin
      wait_d = wait_q + 1'b1;
    end
    case (state_q)
      S_IDLE: state_d = run ? S_T0 : S_IDLE;
      S_T0:   state_d = S_T1;
      S_T1:   if (mem_ready) state_d = S_T2;
      S_T2: begin
        if (w_halt) begin
          state_d = S_HALT;
        end else if (w_nop || !w_known) begin
          // Unknown opcodes retire like a nop, flagged for one cycle
          state_d   = w_end_state;
          illegal_d = !w_known;
        end else begin
          state_d = S_T3;
        end
      end
      S_T3:   state_d = S_T4;
      S_T4:   state_d = S_T5;
      S_T5:   state_d = (w_alu3 || w_imm || w_ldi) ? w_end_state : S_T6;
      S_T6: begin
        if (w_muldiv)                state_d = w_end_state;
        else if (!w_ld || mem_ready) state_d = S_T7;
      end
      S_T7: begin
        if (!w_st || mem_ready) state_d = w_end_state;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
    if (w_timeout) begin
      state_d   = S_HALT;
      mem_err_d = 1'b1;
    end
  end

  // Output logic
  always_comb begin
    r_out   = '0;  r_in    = '0;
    pc_out  = 1'b0; mdr_out = 1'b0; zhi_out = 1'b0; zlo_out = 1'b0; c_out = 1'b0;
    pc_in   = 1'b0; inc_pc  = 1'b0; mar_in  = 1'b0; mdr_in  = 1'b0; mdr_rd = 1'b0;
    ir_in   = 1'b0; y_in    = 1'b0; z_in    = 1'b0; hi_in   = 1'b0; lo_in  = 1'b0;
    read    = 1'b0; write   = 1'b0;
    alu_op  = '0;  step    = 3'd0;
    case (state_q)
      S_T0: begin
        pc_out = 1'b1; mar_in = 1'b1; inc_pc = 1'b1; z_in = 1'b1; alu_op = ALU_INC4;
      end
      S_T1: begin
        step = 3'd1; zlo_out = 1'b1; pc_in = 1'b1; read = 1'b1; mdr_rd = 1'b1;
        mdr_in = mem_ready;
      end
      S_T2: begin
        step = 3'd2; mdr_out = 1'b1; ir_in = 1'b1;
      end
      S_T3: begin
        step = 3'd3; y_in = 1'b1;
        r_out = w_muldiv ? w_ra_oh : w_rb_oh;
      end
      S_T4: begin
        step = 3'd4; z_in = 1'b1;
        if (w_alu3) begin
          r_out = w_rc_oh; alu_op = w_op;
        end else if (w_muldiv) begin
          r_out = w_rb_oh; alu_op = w_op;
        end else if (w_imm) begin
          c_out = 1'b1;
          case (w_op)
            OP_ANDI: alu_op = ALU_AND;
            OP_ORI:  alu_op = ALU_OR;
            default: alu_op = ALU_ADD;
          endcase
        end else begin
          c_out = 1'b1; alu_op = ALU_ADD;
        end
      end
      S_T5: begin
        step = 3'd5; zlo_out = 1'b1;
        if (w_muldiv)          lo_in  = 1'b1;
        else if (w_ld || w_st) mar_in = 1'b1;
        else                   r_in   = w_ra_oh;
      end
      S_T6: begin
        step = 3'd6;
        if (w_muldiv) begin
          zhi_out = 1'b1; hi_in = 1'b1;
        end else if (w_ld) begin
          read = 1'b1; mdr_rd = 1'b1; mdr_in = mem_ready;
        end else begin
          // Store data goes bus -> MDR, so mdr_rd stays low
          r_out = w_ra_oh; mdr_in = 1'b1;
        end
      end
      S_T7: begin
        step = 3'd7;
        if (w_ld) begin
          mdr_out = 1'b1; r_in = w_ra_oh;
        end else begin
          write = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign hi_out     = 1'b0;
  assign lo_out     = 1'b0;
  assign inport_out = 1'b0;
  assign halted     = (state_q == S_HALT);
  assign illegal    = illegal_q;
  assign mem_err    = mem_err_q;

endmodule
`default_nettype wire

// File: tb/tb_minisrc_control_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_minisrc_control_sequencer
// Purpose  : Directed-vector bench. Stimulus pushes the hand-computed output
//            set expected in each driven cycle into a queue; a monitor on the
//            falling edge pops and compares, and checks bus-source exclusivity.
// Revision : 1.0 - initial release
// ============================================================================
module tb_minisrc_control_sequencer;

  localparam logic [7:0]  S_PC = 8'h80, S_MDR = 8'h40, S_ZHI = 8'h20, S_ZLO = 8'h10, S_C = 8'h08;
  localparam logic [11:0] P_PCIN = 12'h800, P_INC = 12'h400, P_MARIN = 12'h200, P_MDRIN = 12'h100,
                          P_MDRRD = 12'h080, P_IRIN = 12'h040, P_YIN = 12'h020, P_ZIN = 12'h010,
                          P_HIIN = 12'h008, P_LOIN = 12'h004, P_RD = 12'h002, P_WR = 12'h001;
  localparam logic [4:0]  A_ADD = 5'b00011, A_AND = 5'b00101, A_MUL = 5'b01111, A_INC4 = 5'b11111;
  localparam logic [2:0]  F_NONE = 3'b000, F_HALT = 3'b100, F_ILL = 3'b010, F_ERR = 3'b001;

  typedef struct {
    int          cyc;
    string       nm;
    logic [2:0]  step;
    logic [15:0] rout;
    logic [15:0] rin;
    logic [7:0]  src;
    logic [11:0] stb;
    logic [4:0]  alu;
    logic [2:0]  flg;
  } exp_t;

  exp_t sb[$];
  exp_t m_e;

  logic        clock, reset, run, mem_ready;
  logic [31:0] ir;
  logic [15:0] r_out, r_in;
  logic        pc_out, mdr_out, zhi_out, zlo_out, c_out, hi_out, lo_out, inport_out;
  logic        pc_in, inc_pc, mar_in, mdr_in, mdr_rd, ir_in, y_in, z_in, hi_in, lo_in;
  logic        read, write, halted, illegal, mem_err;
  logic [4:0]  alu_op;
  logic [2:0]  step;

  minisrc_control_sequencer #(.MEM_TIMEOUT(15)) dut (
    .clock(clock), .reset(reset), .run(run), .ir(ir), .mem_ready(mem_ready),
    .r_out(r_out), .r_in(r_in),
    .pc_out(pc_out), .mdr_out(mdr_out), .zhi_out(zhi_out), .zlo_out(zlo_out),
    .c_out(c_out), .hi_out(hi_out), .lo_out(lo_out), .inport_out(inport_out),
    .pc_in(pc_in), .inc_pc(inc_pc), .mar_in(mar_in), .mdr_in(mdr_in), .mdr_rd(mdr_rd),
    .ir_in(ir_in), .y_in(y_in), .z_in(z_in), .hi_in(hi_in), .lo_in(lo_in),
    .read(read), .write(write), .alu_op(alu_op), .step(step),
    .halted(halted), .illegal(illegal), .mem_err(mem_err)
  );

  logic [7:0]  a_src;
  logic [11:0] a_stb;
  logic [2:0]  a_flg;
  assign a_src = {pc_out, mdr_out, zhi_out, zlo_out, c_out, hi_out, lo_out, inport_out};
  assign a_stb = {pc_in, inc_pc, mar_in, mdr_in, mdr_rd, ir_in, y_in, z_in, hi_in, lo_in, read, write};
  assign a_flg = {halted, illegal, mem_err};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;
  bit done   = 1'b0;

  // One driven cycle: apply mem_ready, record what the outputs must be now
  task automatic cy(input string nm, input logic rdy, input logic [2:0] st,
                    input logic [15:0] ro, input logic [15:0] ri, input logic [7:0] src,
                    input logic [11:0] stb, input logic [4:0] alu, input logic [2:0] flg);
    exp_t e;
    mem_ready = rdy;
    e.cyc = cyc; e.nm = nm; e.step = st; e.rout = ro; e.rin = ri;
    e.src = src; e.stb = stb; e.alu = alu; e.flg = flg;
    sb.push_back(e);
    @(posedge clock); #1;
  endtask

  task automatic fetch(input string nm, input int waits, input logic [2:0] flg0);
    cy({nm, "_T0"}, 1'b0, 3'd0, 16'h0, 16'h0, S_PC, P_MARIN | P_INC | P_ZIN, A_INC4, flg0);
    for (int i = 0; i < waits; i++)
      cy({nm, "_T1w"}, 1'b0, 3'd1, 16'h0, 16'h0, S_ZLO, P_PCIN | P_RD | P_MDRRD, 5'd0, F_NONE);
    cy({nm, "_T1"}, 1'b1, 3'd1, 16'h0, 16'h0, S_ZLO, P_PCIN | P_RD | P_MDRRD | P_MDRIN, 5'd0, F_NONE);
    cy({nm, "_T2"}, 1'b0, 3'd2, 16'h0, 16'h0, S_MDR, P_IRIN, 5'd0, F_NONE);
  endtask

  task automatic idle(input string nm, input logic [2:0] flg);
    cy(nm, 1'b0, 3'd0, 16'h0, 16'h0, 8'h0, 12'h0, 5'd0, flg);
  endtask

  // st Ra=R9, Rb=R3 up to and including T6
  task automatic st_front(input string nm);
    fetch(nm, 0, F_NONE);
    cy({nm, "_T3"}, 1'b0, 3'd3, 16'h0008, 16'h0, 8'h0, P_YIN, 5'd0, F_NONE);
    cy({nm, "_T4"}, 1'b0, 3'd4, 16'h0, 16'h0, S_C, P_ZIN, A_ADD, F_NONE);
    cy({nm, "_T5"}, 1'b0, 3'd5, 16'h0, 16'h0, S_ZLO, P_MARIN, 5'd0, F_NONE);
    cy({nm, "_T6"}, 1'b0, 3'd6, 16'h0200, 16'h0, 8'h0, P_MDRIN, 5'd0, F_NONE);
  endtask

  // Monitor / scoreboard
  always @(negedge clock) begin
    n_chk++;
    if ($countones({r_out, a_src}) <= 1) n_pass++;
    else $display("FAIL src_exclusive cyc=%0d: got r_out=%h src=%b, need at most one source", cyc, r_out, a_src);

    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      m_e = sb.pop_front();
      n_chk++;
      if (m_e.cyc == cyc &&
          {step, r_out, r_in, a_src, a_stb, alu_op, a_flg} ===
          {m_e.step, m_e.rout, m_e.rin, m_e.src, m_e.stb, m_e.alu, m_e.flg}) begin
        n_pass++;
      end else begin
        $display("FAIL %s cyc=%0d: got step=%0d rout=%h rin=%h src=%h stb=%h alu=%b flg=%b; exp step=%0d rout=%h rin=%h src=%h stb=%h alu=%b flg=%b",
                 m_e.nm, cyc, step, r_out, r_in, a_src, a_stb, alu_op, a_flg,
                 m_e.step, m_e.rout, m_e.rin, m_e.src, m_e.stb, m_e.alu, m_e.flg);
      end
    end

    if (done) begin
      n_chk++;
      if (sb.size() == 0) n_pass++;
      else $display("FAIL sb_drain: got %0d pending entries, need 0", sb.size());
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout, need finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; run = 1'b0; ir = 32'h0; mem_ready = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b0;
    idle("reset_idle", F_NONE);
    run = 1'b1;
    ir  = 32'h19890000;                     // add R3,R1,R2
    idle("idle_run", F_NONE);

    fetch("add", 0, F_NONE);
    cy("add_T3", 1'b0, 3'd3, 16'h0002, 16'h0, 8'h0, P_YIN, 5'd0, F_NONE);
    cy("add_T4", 1'b0, 3'd4, 16'h0004, 16'h0, 8'h0, P_ZIN, A_ADD, F_NONE);
    cy("add_T5", 1'b0, 3'd5, 16'h0, 16'h0008, S_ZLO, 12'h0, 5'd0, F_NONE);

    ir = 32'h00900000;                      // ld R1, Rb=R2
    fetch("ld", 1, F_NONE);
    cy("ld_T3", 1'b0, 3'd3, 16'h0004, 16'h0, 8'h0, P_YIN, 5'd0, F_NONE);
    cy("ld_T4", 1'b0, 3'd4, 16'h0, 16'h0, S_C, P_ZIN, A_ADD, F_NONE);
    cy("ld_T5", 1'b0, 3'd5, 16'h0, 16'h0, S_ZLO, P_MARIN, 5'd0, F_NONE);
    for (int i = 0; i < 3; i++)
      cy("ld_T6w", 1'b0, 3'd6, 16'h0, 16'h0, 8'h0, P_RD | P_MDRRD, 5'd0, F_NONE);
    cy("ld_T6", 1'b1, 3'd6, 16'h0, 16'h0, 8'h0, P_RD | P_MDRRD | P_MDRIN, 5'd0, F_NONE);
    cy("ld_T7", 1'b0, 3'd7, 16'h0, 16'h0002, S_MDR, 12'h0, 5'd0, F_NONE);

    ir = 32'h7A280000;                      // mul R4,R5
    fetch("mul", 0, F_NONE);
    cy("mul_T3", 1'b0, 3'd3, 16'h0010, 16'h0, 8'h0, P_YIN, 5'd0, F_NONE);
    cy("mul_T4", 1'b0, 3'd4, 16'h0020, 16'h0, 8'h0, P_ZIN, A_MUL, F_NONE);
    cy("mul_T5", 1'b0, 3'd5, 16'h0, 16'h0, S_ZLO, P_LOIN, 5'd0, F_NONE);
    cy("mul_T6", 1'b0, 3'd6, 16'h0, 16'h0, S_ZHI, P_HIIN, 5'd0, F_NONE);

    ir = 32'h6B380000;                      // andi R6,R7,C
    fetch("andi", 2, F_NONE);
    cy("andi_T3", 1'b0, 3'd3, 16'h0080, 16'h0, 8'h0, P_YIN, 5'd0, F_NONE);
    cy("andi_T4", 1'b0, 3'd4, 16'h0, 16'h0, S_C, P_ZIN, A_AND, F_NONE);
    cy("andi_T5", 1'b0, 3'd5, 16'h0, 16'h0040, S_ZLO, 12'h0, 5'd0, F_NONE);

    ir = 32'h14980000;                      // st R9, Rb=R3, 2 write waits
    st_front("st");
    cy("st_T7w", 1'b0, 3'd7, 16'h0, 16'h0, 8'h0, P_WR, 5'd0, F_NONE);
    cy("st_T7w", 1'b0, 3'd7, 16'h0, 16'h0, 8'h0, P_WR, 5'd0, F_NONE);
    cy("st_T7", 1'b1, 3'd7, 16'h0, 16'h0, 8'h0, P_WR, 5'd0, F_NONE);

    ir = 32'hA8000000;                      // opcode 10101
    fetch("ill", 0, F_NONE);
    ir  = 32'hD0000000;                     // nop, then stop
    run = 1'b0;
    fetch("nop", 0, F_ILL);
    idle("idle_after_nop", F_NONE);
    run = 1'b1;
    ir  = 32'h14980000;
    idle("idle_run2", F_NONE);

    st_front("sterr");
    for (int i = 0; i < 15; i++)
      cy("sterr_T7w", 1'b0, 3'd7, 16'h0, 16'h0, 8'h0, P_WR, 5'd0, F_NONE);
    idle("halt_err", F_HALT | F_ERR);
    cy("halt_err_hold", 1'b1, 3'd0, 16'h0, 16'h0, 8'h0, 12'h0, 5'd0, F_HALT | F_ERR);

    reset = 1'b1; mem_ready = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0; run = 1'b0;
    idle("rst_from_halt", F_NONE);
    run = 1'b1;
    ir  = 32'hD8000000;                     // halt
    idle("idle_run3", F_NONE);
    cy("rst_T0", 1'b0, 3'd0, 16'h0, 16'h0, S_PC, P_MARIN | P_INC | P_ZIN, A_INC4, F_NONE);
    reset = 1'b1;
    cy("rst_T1w", 1'b0, 3'd1, 16'h0, 16'h0, S_ZLO, P_PCIN | P_RD | P_MDRRD, 5'd0, F_NONE);
    reset = 1'b0; run = 1'b0;
    idle("rst_midT1", F_NONE);

    run = 1'b1;
    idle("idle_run4", F_NONE);
    fetch("halt", 0, F_NONE);
    idle("halted", F_HALT);
    cy("halted_hold", 1'b1, 3'd0, 16'h0, 16'h0, 8'h0, 12'h0, 5'd0, F_HALT);

    done = 1'b1;
  end

endmodule
`default_nettype wire
